// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scancode set 2 prefix decoder with key-event register and game-key flags
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_release,
  output logic       jump_held,
  output logic       duck_held,
  output logic       start_pulse,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;
  logic             w_ignored;
  logic             w_is_e0;
  logic             w_is_f0;
  logic             w_evt_fire;
  logic             w_evt_ext;
  logic             w_evt_rel;
  logic             w_evt_load;
  logic             r_space_held;
  logic             r_up_held;
  logic             r_duck_held;
  logic             r_enter_held;

  assign w_is_e0   = (byte_data == 8'hE0);
  assign w_is_f0   = (byte_data == 8'hF0);
  assign w_ignored = (byte_data == 8'h00) || (byte_data == 8'hAA) || (byte_data == 8'hFA) ||
                     (byte_data == 8'hFE) || (byte_data == 8'hFF);
  // An arriving byte always wins over a timeout in the same cycle.
  assign w_timeout = (r_state != IDLE) && !byte_valid &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_evt_load = w_evt_fire && (!evt_valid || evt_ready);

  // State register.
  always_ff @(posedge Clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode: prefix bytes walk the state, any other byte completes a key.
  always_comb begin
    w_next_state = r_state;
    if (byte_valid) begin
      if (w_ignored) begin
        w_next_state = IDLE;
      end else begin
        case (r_state)
          IDLE:    w_next_state = w_is_e0 ? EXT : (w_is_f0 ? BRK : IDLE);
          EXT:     w_next_state = w_is_f0 ? EXT_BRK : (w_is_e0 ? EXT : IDLE);
          BRK:     w_next_state = w_is_e0 ? EXT_BRK : (w_is_f0 ? BRK : IDLE);
          EXT_BRK: w_next_state = (w_is_e0 || w_is_f0) ? EXT_BRK : IDLE;
          default: w_next_state = IDLE;
        endcase
      end
    end else if (w_timeout) begin
      w_next_state = IDLE;
    end
  end

  // Output decode: a non-prefix, non-ignored byte completes an event flavoured by the state.
  always_comb begin
    w_evt_fire = byte_valid && !w_ignored && !w_is_e0 && !w_is_f0;
    w_evt_ext  = (r_state == EXT) || (r_state == EXT_BRK);
    w_evt_rel  = (r_state == BRK) || (r_state == EXT_BRK);
  end

  // Inter-byte timeout counter, only runs while a prefix is pending.
  always_ff @(posedge Clock) begin
    if (!reset || byte_valid || (r_state == IDLE) || w_timeout) r_cnt <= '0;
    else                                                        r_cnt <= r_cnt + 1'b1;
  end

  // Event output register; a busy register drops the new event and flags overflow.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      evt_valid   <= 1'b0;
      evt_code    <= 8'h00;
      evt_ext     <= 1'b0;
      evt_release <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      overflow <= w_evt_fire && evt_valid && !evt_ready;
      if (w_evt_load) begin
        evt_valid   <= 1'b1;
        evt_code    <= byte_data;
        evt_ext     <= w_evt_ext;
        evt_release <= w_evt_rel;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

  // Game-key state tracks every decoded event, independent of the consumer handshake.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      r_space_held <= 1'b0;
      r_up_held    <= 1'b0;
      r_duck_held  <= 1'b0;
      r_enter_held <= 1'b0;
      start_pulse  <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (w_evt_fire) begin
        if (!w_evt_ext && byte_data == 8'h29) r_space_held <= !w_evt_rel;
        if ( w_evt_ext && byte_data == 8'h75) r_up_held    <= !w_evt_rel;
        if ( w_evt_ext && byte_data == 8'h72) r_duck_held  <= !w_evt_rel;
        if (!w_evt_ext && byte_data == 8'h5A) begin
          r_enter_held <= !w_evt_rel;
          start_pulse  <= !w_evt_rel && !r_enter_held;
        end
      end
    end
  end

  assign jump_held = r_space_held || r_up_held;
  assign duck_held = r_duck_held;

endmodule
